// File: rtl/lsu_mem_arbiter_pkg.sv
// rtl/lsu_mem_arbiter_pkg.sv - shared types for the LSU data_mem request arbiter
package lsu_mem_arbiter_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK_LD, ARB_LOCK_ST} lsu_arb_state_t;
    typedef enum logic {GRANT_LD, GRANT_ST} lsu_grant_t;

endpackage

// File: rtl/lsu_mem_arbiter_if.sv
// rtl/lsu_mem_arbiter_if.sv - load/store request, data_mem and response signals of the arbiter
interface lsu_mem_arbiter_if #(parameter int RS_ID_WIDTH = 7);

    logic                   ld_valid;
    logic                   ld_ready;
    logic [RS_ID_WIDTH-1:0] ld_rs_id;
    logic [4:0]             ld_result_reg_addr;
    logic [31:0]            ld_address;
    logic [3:0]             ld_read_en;

    logic                   st_valid;
    logic                   st_ready;
    logic [31:0]            st_address;
    logic [3:0]             st_write_en;
    logic [31:0]            st_write_data;

    logic                   mem_input_valid;
    logic                   mem_input_ready;
    logic [RS_ID_WIDTH-1:0] mem_rs_id;
    logic [4:0]             mem_result_reg_addr;
    logic [31:0]            mem_address;
    logic [3:0]             mem_write_en;
    logic [31:0]            mem_write_data;
    logic [3:0]             mem_read_en;
    logic                   mem_output_valid;
    logic                   mem_output_ready;

    logic                   ld_resp_valid;
    logic                   ld_resp_ready;
    logic [3:0]             outstanding;
    logic                   quiesced;

    modport master (
        input  ld_valid, ld_rs_id, ld_result_reg_addr, ld_address, ld_read_en,
        input  st_valid, st_address, st_write_en, st_write_data,
        input  mem_input_ready, mem_output_valid, ld_resp_ready,
        output ld_ready, st_ready,
        output mem_input_valid, mem_rs_id, mem_result_reg_addr, mem_address,
        output mem_write_en, mem_write_data, mem_read_en, mem_output_ready,
        output ld_resp_valid, outstanding, quiesced
    );

    modport slave (
        output ld_valid, ld_rs_id, ld_result_reg_addr, ld_address, ld_read_en,
        output st_valid, st_address, st_write_en, st_write_data,
        output mem_input_ready, mem_output_valid, ld_resp_ready,
        input  ld_ready, st_ready,
        input  mem_input_valid, mem_rs_id, mem_result_reg_addr, mem_address,
        input  mem_write_en, mem_write_data, mem_read_en, mem_output_ready,
        input  ld_resp_valid, outstanding, quiesced
    );

endinterface

// File: rtl/lsu_mem_arbiter_rr_arbiter2.sv
// rtl/lsu_mem_arbiter_rr_arbiter2.sv - two-way round-robin pick, history advances only on a handshake
module rr_arbiter2
    import lsu_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_ld,
    input  logic       req_st,
    input  logic       update,
    input  lsu_grant_t update_grant,
    output logic       grant_valid,
    output lsu_grant_t grant
);

    lsu_grant_t last_grant;

    // Starting from STORE hands the very first tie to the load side.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_ST;
        end else if (update) begin
            last_grant <= update_grant;
        end
    end

    always_comb begin
        grant_valid = req_ld | req_st;
        if (req_ld && req_st) begin
            grant = (last_grant == GRANT_ST) ? GRANT_LD : GRANT_ST;
        end else if (req_ld) begin
            grant = GRANT_LD;
        end else begin
            grant = GRANT_ST;
        end
    end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// rtl/lsu_mem_arbiter.sv - shares the data_mem request port between LSU loads and stores
module lsu_mem_arbiter
    import lsu_mem_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    lsu_mem_arbiter_if.master bus
);

    lsu_arb_state_t state;
    logic [3:0]     outstanding;
    logic           bubble;
    logic           ld_eligible;
    logic           arb_valid;
    lsu_grant_t     arb_grant;
    logic           gnt_valid;
    lsu_grant_t     gnt;
    logic           sel_ld;
    logic           sel_st;
    logic           ld_hs;
    logic           st_hs;
    logic           resp_hs;

    assign ld_eligible = bus.ld_valid && (outstanding < 4'(MAX_OUTSTANDING));

    rr_arbiter2 u_rr (
        .clk          (clk),
        .rst          (rst),
        .req_ld       (ld_eligible),
        .req_st       (bus.st_valid),
        .update       (ld_hs | st_hs),
        .update_grant (gnt),
        .grant_valid  (arb_valid),
        .grant        (arb_grant)
    );

    // A held lock ignores credits and the other side; the bubble cycle after it grants nobody.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = GRANT_LD;
        unique case (state)
            ARB_LOCK_LD: begin
                gnt_valid = 1'b1;
                gnt       = GRANT_LD;
            end
            ARB_LOCK_ST: begin
                gnt_valid = 1'b1;
                gnt       = GRANT_ST;
            end
            default: begin
                gnt_valid = arb_valid && !bubble;
                gnt       = arb_grant;
            end
        endcase
    end

    assign sel_ld  = gnt_valid && (gnt == GRANT_LD);
    assign sel_st  = gnt_valid && (gnt == GRANT_ST);
    assign ld_hs   = sel_ld && bus.mem_input_ready;
    assign st_hs   = sel_st && bus.mem_input_ready;
    assign resp_hs = bus.mem_output_valid && bus.ld_resp_ready;

    assign bus.mem_input_valid     = gnt_valid;
    assign bus.mem_rs_id           = sel_ld ? bus.ld_rs_id : '0;
    assign bus.mem_result_reg_addr = sel_ld ? bus.ld_result_reg_addr : '0;
    assign bus.mem_address         = sel_ld ? bus.ld_address : (sel_st ? bus.st_address : '0);
    assign bus.mem_read_en         = sel_ld ? bus.ld_read_en : '0;
    assign bus.mem_write_en        = sel_st ? bus.st_write_en : '0;
    assign bus.mem_write_data      = sel_st ? bus.st_write_data : '0;
    assign bus.ld_ready            = ld_hs;
    assign bus.st_ready            = st_hs;
    assign bus.ld_resp_valid       = bus.mem_output_valid;
    assign bus.mem_output_ready    = bus.ld_resp_ready;
    assign bus.outstanding         = outstanding;
    assign bus.quiesced            = (state == ARB_IDLE) && (outstanding == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            outstanding <= '0;
            bubble      <= 1'b0;
        end else begin
            bubble <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (gnt_valid && !bus.mem_input_ready) begin
                        state <= (gnt == GRANT_LD) ? ARB_LOCK_LD : ARB_LOCK_ST;
                    end
                end
                default: begin
                    if (bus.mem_input_ready) begin
                        state  <= ARB_IDLE;
                        bubble <= 1'b1;
                    end
                end
            endcase
            if (ld_hs && !resp_hs) begin
                outstanding <= outstanding + 4'd1;
            end else if (resp_hs && !ld_hs && (outstanding != 4'd0)) begin
                outstanding <= outstanding - 4'd1;
            end
        end
    end

    // A response with no load in flight means data_mem or the consumer broke protocol.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(resp_hs && (outstanding == 4'd0)));
        end
    end

endmodule
